alu_cmd_issuer: RTL

- Initiator side of the 4-bit ALU interface.
- Buffers operation requests in a small command FIFO, drives operand and select lines to a combinational ALU slice, and registers the ALU result and flags into a response holding stage with valid/ready flow control.
- Also sanitises the flags and detects zero-flag inconsistencies in the ALU response.
- Sits between the datapath/test harness control and the ALU.

---
 rtl/alu_cmd_issuer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
//
// Initiator side of the 4-bit ALU interface. Operation requests are queued
// in a small command FIFO. The FIFO head drives a combinational ALU slice,
// and the result of the head command is captured into a response holding
// stage with valid/ready flow control. Carry/overflow flags are forced to 0
// for non-arithmetic operations, because the ALU leaves stale values on them.
// A sticky error flag records any response whose zero flag disagrees with
// its result.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_a, cmd_b, cmd_sel payload
//   alu_a/b/sel         operands and select to the ALU (0 when FIFO empty)
//   alu_out/cf/of/zf    combinational ALU result and flags
//   rsp_valid/ready     response handshake
//   rsp_out/sel/cf/of/zf captured result, select and sanitised flags
//   level               FIFO occupancy
//   err_zf              sticky zero-flag mismatch
// ---------------------------------------------------------------------------
module alu_cmd_issuer #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [W-1:0]             cmd_a,
  input  logic [W-1:0]             cmd_b,
  input  logic [2:0]               cmd_sel,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  output logic [2:0]               alu_sel,
  input  logic [W-1:0]             alu_out,
  input  logic                     alu_cf,
  input  logic                     alu_of,
  input  logic                     alu_zf,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [W-1:0]             rsp_out,
  output logic [2:0]               rsp_sel,
  output logic                     rsp_cf,
  output logic                     rsp_of,
  output logic                     rsp_zf,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_zf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEVEL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          not_empty;
  logic          push;
  logic          issue;
  logic          arith;

  assign head      = mem[rd_ptr];
  assign not_empty = (level != '0);
  // Registered occupancy only: a full FIFO does not accept a command in the
  // same cycle a pop frees a slot.
  assign cmd_ready = (level < FULL_LEVEL);
  assign push      = cmd_valid && cmd_ready;
  assign issue     = not_empty && (!rsp_valid || rsp_ready);
  // add (000) and sub (001) are the only ops that produce meaningful cf/of.
  assign arith     = (head.sel[2:1] == 2'b00);

  // ALU drive comes straight from the registered head entry, forced to 0
  // when the FIFO is empty so stale entries never reach the ALU.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (not_empty) begin
      alu_a   = head.a;
      alu_b   = head.b;
      alu_sel = head.sel;
    end
  end

  // NOTE: the storage array has no reset; entries are only observable
  // through the head while level != 0, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, sel: cmd_sel};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      rsp_sel   <= '0;
      rsp_cf    <= 1'b0;
      rsp_of    <= 1'b0;
      rsp_zf    <= 1'b0;
      err_zf    <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;

      case ({push, issue})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase

      if (issue) begin
        rsp_valid <= 1'b1;
        rsp_out   <= alu_out;
        rsp_sel   <= head.sel;
        rsp_zf    <= alu_zf;
        rsp_cf    <= arith ? alu_cf : 1'b0;
        rsp_of    <= arith ? alu_of : 1'b0;
        if (alu_zf != (alu_out == '0)) err_zf <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
